// File: rtl/cpu_datapath.sv
// Register/ALU/memory datapath of the 8-bit accumulator CPU.
// Executes the controller's strobes on posedge clk and reports IR and Z/C back.
module cpu_datapath #(
    parameter int DW = 8,
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    MUX_sel,
    input  logic [1:0]    ALU_op,
    input  logic          AR_load,
    input  logic          PC_load,
    input  logic          PC_inc,
    input  logic          AC_load,
    input  logic          ZC_load,
    input  logic          IR_load,
    input  logic          DR_load,
    input  logic          MEM_write,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [DW-1:0] prog_data,
    output logic [DW-1:0] Instruction,
    output logic          flag_z,
    output logic          flag_c,
    output logic [DW-1:0] dev_bus,
    output logic [DW-1:0] dev_ac,
    output logic [AW-1:0] dev_pc,
    output logic [AW-1:0] dev_ar
);

    localparam int            DEPTH  = 1 << AW;
    localparam logic [AW-1:0] PC_ONE = AW'(1);

    logic [AW-1:0] ar_r;
    logic [AW-1:0] pc_r;
    logic [DW-1:0] dr_r;
    logic [DW-1:0] ac_r;
    logic [DW-1:0] ir_r;
    logic          z_r;
    logic          c_r;
    logic [DW-1:0] mem_r [DEPTH];

    logic [DW-1:0] bus_s;
    logic [DW:0]   sum_s;
    logic [DW-1:0] alu_res_s;
    logic          alu_c_s;
    logic          alu_z_s;

    // Bus source select; memory is read asynchronously at the current AR.
    always_comb begin
        bus_s = ac_r;
        case (MUX_sel)
            2'b00:   bus_s = ac_r;
            2'b01:   bus_s = dr_r;
            2'b10:   bus_s = {{(DW-AW){1'b0}}, pc_r};
            2'b11:   bus_s = mem_r[ar_r];
            default: bus_s = ac_r;
        endcase
    end

    assign sum_s = {1'b0, ac_r} + {1'b0, dr_r};

    // ALU result and carry; only ADD can produce a carry.
    always_comb begin
        alu_res_s = sum_s[DW-1:0];
        alu_c_s   = 1'b0;
        case (ALU_op)
            2'b00: begin
                alu_res_s = sum_s[DW-1:0];
                alu_c_s   = sum_s[DW];
            end
            2'b01:   alu_res_s = dr_r;
            2'b10:   alu_res_s = ac_r & dr_r;
            2'b11:   alu_res_s = ~ac_r;
            default: alu_res_s = sum_s[DW-1:0];
        endcase
    end

    assign alu_z_s = (alu_res_s == {DW{1'b0}});

    // Register file and RAM; RAM keeps its contents through reset and a
    // program-load write takes the port over from a same-cycle MEM_write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ar_r <= {AW{1'b0}};
            pc_r <= {AW{1'b0}};
            dr_r <= {DW{1'b0}};
            ac_r <= {DW{1'b0}};
            ir_r <= {DW{1'b0}};
            z_r  <= 1'b0;
            c_r  <= 1'b0;
        end else begin
            if (AR_load) ar_r <= bus_s[AW-1:0];
            if (PC_load) begin
                pc_r <= bus_s[AW-1:0];
            end else if (PC_inc) begin
                pc_r <= pc_r + PC_ONE;
            end
            if (DR_load) dr_r <= bus_s;
            if (IR_load) ir_r <= bus_s;
            if (AC_load) ac_r <= alu_res_s;
            if (ZC_load) begin
                z_r <= alu_z_s;
                c_r <= alu_c_s;
            end
            if (prog_we) begin
                mem_r[prog_addr] <= prog_data;
            end else if (MEM_write) begin
                mem_r[ar_r] <= bus_s;
            end
        end
    end

    assign Instruction = ir_r;
    assign flag_z      = z_r;
    assign flag_c      = c_r;
    assign dev_bus     = bus_s;
    assign dev_ac      = ac_r;
    assign dev_pc      = pc_r;
    assign dev_ar      = ar_r;

endmodule
